// File: rtl/ball_paddle_gen.sv
// ball_paddle_gen: one-ball, one-paddle game engine with per-frame motion, lives and pixel colouring
module ball_paddle_gen #(
  parameter int BALL_SIZE  = 8,
  parameter int BALL_V     = 2,
  parameter int PADDLE_W   = 64,
  parameter int PADDLE_H   = 8,
  parameter int PADDLE_Y   = 464,
  parameter int PADDLE_V   = 4,
  parameter int LIVES_INIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        video_on,
  input  logic        p_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_serve,
  output logic [11:0] rgb,
  output logic        miss,
  output logic [1:0]  lives,
  output logic        game_over
);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] BV     = 11'(BALL_V);
  localparam logic [10:0] PW     = 11'(PADDLE_W);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [10:0] PY     = 11'(PADDLE_Y);
  localparam logic [10:0] PV     = 11'(PADDLE_V);
  localparam logic [10:0] PX_MAX = 11'd640 - PW;
  localparam logic [10:0] PX_RST = PX_MAX >> 1;
  localparam logic [10:0] BX_OFF = (PW >> 1) - (BS >> 1);
  localparam logic [10:0] BY_SRV = PY - BS;
  localparam logic [10:0] BX_MAX = 11'd640 - BS - BV;
  localparam logic [1:0]  LI     = 2'(LIVES_INIT);

  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

  state_t      r_state, w_state_n;
  logic [10:0] r_paddle_x, r_ball_x, r_ball_y;
  logic [10:0] w_paddle_n, w_ball_x_n, w_ball_y_n;
  logic        r_dx, r_dy, w_dx_r, w_dy_r, w_dx_n, w_dy_n;
  logic [1:0]  r_lives, w_lives_n;
  logic        r_miss;
  logic [11:0] r_rgb;
  logic        w_refr, w_left, w_right, w_hit, w_miss, w_ball_px, w_paddle_px;

  assign w_refr  = p_tick && pixel_x == 11'd0 && pixel_y == 11'd481;
  assign w_right = btn_right && !btn_left && r_state != OVER;
  assign w_left  = btn_left && !btn_right && r_state != OVER;
  assign w_paddle_n = w_right ? (r_paddle_x > PX_MAX - PV ? PX_MAX : r_paddle_x + PV) :
                      w_left  ? (r_paddle_x < PV ? 11'd0 : r_paddle_x - PV) : r_paddle_x;
  assign w_hit  = r_dy && r_ball_y + BS >= PY && r_ball_y + BS <= PY + BV &&
                  r_ball_x + BS > r_paddle_x && r_ball_x < r_paddle_x + PW;
  assign w_miss = r_state == PLAY && !w_hit && r_ball_y >= 11'd480;
  assign w_dx_r = (r_dx && r_ball_x >= BX_MAX) ? 1'b0 : (!r_dx && r_ball_x <= BV) ? 1'b1 : r_dx;
  assign w_dy_r = w_hit ? 1'b0 : (!r_dy && r_ball_y <= BV) ? 1'b1 : r_dy;
  assign w_ball_px   = pixel_x >= r_ball_x && pixel_x < r_ball_x + BS &&
                       pixel_y >= r_ball_y && pixel_y < r_ball_y + BS;
  assign w_paddle_px = pixel_x >= r_paddle_x && pixel_x < r_paddle_x + PW &&
                       pixel_y >= PY && pixel_y < PY + PH;

  // game state advances once per frame
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= SERVE;
    else if (w_refr) r_state <= w_state_n;

  // next state, lives and ball motion; outside PLAY the ball rides centred on the paddle
  always_comb begin
    w_state_n  = r_state;
    w_lives_n  = r_lives;
    w_ball_x_n = w_paddle_n + BX_OFF;
    w_ball_y_n = BY_SRV;
    w_dx_n     = 1'b1;
    w_dy_n     = 1'b0;
    if (r_state == SERVE) begin
      w_state_n = btn_serve ? PLAY : SERVE;
    end else if (r_state == PLAY) begin
      if (w_miss) begin
        w_lives_n = r_lives - 2'd1;
        w_state_n = r_lives == 2'd1 ? OVER : SERVE;
      end else begin
        w_dx_n     = w_dx_r;
        w_dy_n     = w_dy_r;
        w_ball_x_n = w_dx_r ? r_ball_x + BV : r_ball_x - BV;
        w_ball_y_n = w_dy_r ? r_ball_y + BV : r_ball_y - BV;
      end
    end else if (btn_serve) begin
      w_state_n = SERVE;
      w_lives_n = LI;
    end
  end

  // positions, directions and lives update per frame; miss pulses for the one clk after the losing frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_paddle_x <= PX_RST;
      r_ball_x   <= PX_RST + BX_OFF;
      r_ball_y   <= BY_SRV;
      r_dx       <= 1'b1;
      r_dy       <= 1'b0;
      r_lives    <= LI;
      r_miss     <= 1'b0;
    end else begin
      r_miss <= w_refr && w_miss;
      if (w_refr) begin
        r_paddle_x <= w_paddle_n;
        r_ball_x   <= w_ball_x_n;
        r_ball_y   <= w_ball_y_n;
        r_dx       <= w_dx_n;
        r_dy       <= w_dy_n;
        r_lives    <= w_lives_n;
      end
    end

  // pixel colour, ball over paddle over background, one p_tick behind the scan position
  always_ff @(posedge clk or posedge reset)
    if (reset) r_rgb <= 12'h000;
    else if (p_tick) r_rgb <= !video_on ? 12'h000 : w_ball_px ? 12'hF00 : w_paddle_px ? 12'h0F0 :
                              r_state == OVER ? 12'h400 : 12'h000;

  assign rgb       = r_rgb;
  assign miss      = r_miss;
  assign lives     = r_lives;
  assign game_over = r_state == OVER;
endmodule

// File: tb/tb_ball_paddle_gen.sv
// tb_ball_paddle_gen: directed scenarios for rendering, serve, reflection, paddle, misses and reset
module tb_ball_paddle_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pixel_x, pixel_y;
  logic        video_on, p_tick, btn_left, btn_right, btn_serve;
  logic [11:0] rgb;
  logic        miss;
  logic [1:0]  lives;
  logic        game_over;
  int          checks = 0;
  int          passed = 0;
  int          miss_cnt = 0;

  ball_paddle_gen dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .p_tick(p_tick), .btn_left(btn_left), .btn_right(btn_right), .btn_serve(btn_serve),
    .rgb(rgb), .miss(miss), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_x = 11'd0; pixel_y = 11'd481; video_on = 1'b0; p_tick = 1'b1;
      @(negedge clk);
      p_tick = 1'b0; pixel_x = 11'd700; pixel_y = 11'd600;
      miss_cnt += int'(miss);
    end
  endtask

  task automatic probe(input int x, input int y, output logic [11:0] c);
    @(negedge clk);
    pixel_x = 11'(x); pixel_y = 11'(y); video_on = 1'b1; p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    c = rgb;
  endtask

  task automatic ball_at(input int x, input int y, output logic ok);
    logic [11:0] a, b, c;
    probe(x, y, a);
    probe(x - 1, y, b);
    probe(x, y - 1, c);
    ok = a == 12'hF00 && b != 12'hF00 && c != 12'hF00;
  endtask

  task automatic test_reset();
    reset = 1'b1; pixel_x = 11'd700; pixel_y = 11'd600; video_on = 1'b0; p_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_serve = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rgb !== 12'h000) $display("FAIL reset_rgb: got %h want 000", rgb); else passed++;
    checks++; if (miss !== 1'b0) $display("FAIL reset_miss: got %b want 0", miss); else passed++;
    checks++; if (lives !== 2'd3) $display("FAIL reset_lives: got %0d want 3", lives); else passed++;
    checks++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %b want 0", game_over); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_render();
    logic [11:0] c;
    probe(320, 460, c);
    checks++; if (c !== 12'hF00) $display("FAIL render_ball: got %h want F00", c); else passed++;
    probe(300, 468, c);
    checks++; if (c !== 12'h0F0) $display("FAIL render_paddle: got %h want 0F0", c); else passed++;
    probe(100, 100, c);
    checks++; if (c !== 12'h000) $display("FAIL render_bg: got %h want 000", c); else passed++;
    @(negedge clk);
    pixel_x = 11'd320; pixel_y = 11'd460; video_on = 1'b1; p_tick = 1'b0;
    @(negedge clk);
    checks++; if (rgb !== 12'h000) $display("FAIL render_hold: got %h want 000", rgb); else passed++;
    p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    checks++; if (rgb !== 12'hF00) $display("FAIL render_latency: got %h want F00", rgb); else passed++;
    video_on = 1'b0; p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    checks++; if (rgb !== 12'h000) $display("FAIL render_blank: got %h want 000", rgb); else passed++;
  endtask

  task automatic test_serve();
    logic ok;
    btn_serve = 1'b1;
    ticks(1);
    btn_serve = 1'b0;
    ball_at(316, 456, ok);
    checks++; if (ok !== 1'b1) $display("FAIL serve_tick_pos: got %b want 1", ok); else passed++;
    ticks(1);
    ball_at(318, 454, ok);
    checks++; if (ok !== 1'b1) $display("FAIL serve_first_step: got %b want 1", ok); else passed++;
  endtask

  task automatic test_reflect();
    logic ok;
    ticks(156);
    ball_at(630, 142, ok);
    checks++; if (ok !== 1'b1) $display("FAIL reflect_pre_right: got %b want 1", ok); else passed++;
    ticks(1);
    ball_at(628, 140, ok);
    checks++; if (ok !== 1'b1) $display("FAIL reflect_right: got %b want 1", ok); else passed++;
    ticks(69);
    ball_at(490, 2, ok);
    checks++; if (ok !== 1'b1) $display("FAIL reflect_pre_top: got %b want 1", ok); else passed++;
    ticks(1);
    ball_at(488, 4, ok);
    checks++; if (ok !== 1'b1) $display("FAIL reflect_top: got %b want 1", ok); else passed++;
  endtask

  task automatic test_miss();
    logic ok;
    miss_cnt = 0;
    ticks(238);
    checks++; if (miss_cnt !== 0) $display("FAIL miss_early: got %0d want 0", miss_cnt); else passed++;
    checks++; if (lives !== 2'd3) $display("FAIL miss_lives_before: got %0d want 3", lives); else passed++;
    ticks(1);
    checks++; if (miss_cnt !== 1) $display("FAIL miss_pulse: got %0d want 1", miss_cnt); else passed++;
    checks++; if (lives !== 2'd2) $display("FAIL miss_lives_after: got %0d want 2", lives); else passed++;
    @(negedge clk);
    checks++; if (miss !== 1'b0) $display("FAIL miss_width: got %b want 0", miss); else passed++;
    ball_at(316, 456, ok);
    checks++; if (ok !== 1'b1) $display("FAIL miss_reserve_pos: got %b want 1", ok); else passed++;
  endtask

  task automatic test_async_reset();
    logic [11:0] c;
    logic ok;
    btn_serve = 1'b1;
    ticks(1);
    btn_serve = 1'b0;
    ticks(3);
    probe(322, 450, c);
    checks++; if (c !== 12'hF00) $display("FAIL areset_pre_ball: got %h want F00", c); else passed++;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (rgb !== 12'h000) $display("FAIL areset_rgb: got %h want 000", rgb); else passed++;
    checks++; if (lives !== 2'd3) $display("FAIL areset_lives: got %0d want 3", lives); else passed++;
    checks++; if (game_over !== 1'b0 || miss !== 1'b0) $display("FAIL areset_flags: got %b%b want 00", game_over, miss); else passed++;
    @(negedge clk);
    reset = 1'b0;
    ticks(1);
    ball_at(316, 456, ok);
    checks++; if (ok !== 1'b1) $display("FAIL areset_ball_home: got %b want 1", ok); else passed++;
  endtask

  task automatic test_paddle();
    logic [11:0] c;
    logic ok;
    btn_right = 1'b1;
    ticks(200);
    btn_right = 1'b0;
    probe(576, 464, c);
    checks++; if (c !== 12'h0F0) $display("FAIL paddle_right_edge: got %h want 0F0", c); else passed++;
    probe(575, 464, c);
    checks++; if (c !== 12'h000) $display("FAIL paddle_right_sat: got %h want 000", c); else passed++;
    ball_at(604, 456, ok);
    checks++; if (ok !== 1'b1) $display("FAIL paddle_ball_follow: got %b want 1", ok); else passed++;
    btn_right = 1'b1; btn_left = 1'b1;
    ticks(5);
    btn_right = 1'b0; btn_left = 1'b0;
    probe(575, 464, c);
    checks++; if (c !== 12'h000) $display("FAIL paddle_both_hold: got %h want 000", c); else passed++;
    probe(576, 464, c);
    checks++; if (c !== 12'h0F0) $display("FAIL paddle_both_edge: got %h want 0F0", c); else passed++;
    btn_left = 1'b1;
    ticks(200);
    btn_left = 1'b0;
    probe(0, 464, c);
    checks++; if (c !== 12'h0F0) $display("FAIL paddle_left_edge: got %h want 0F0", c); else passed++;
    probe(64, 464, c);
    checks++; if (c !== 12'h000) $display("FAIL paddle_left_end: got %h want 000", c); else passed++;
  endtask

  task automatic test_game_over();
    logic [11:0] c;
    for (int r = 0; r < 3; r++) begin
      btn_serve = 1'b1;
      ticks(1);
      btn_serve = 1'b0;
      miss_cnt = 0;
      ticks(466);
      checks++; if (miss_cnt !== 0) $display("FAIL over_round%0d_early: got %0d want 0", r, miss_cnt); else passed++;
      ticks(1);
      checks++; if (miss_cnt !== 1) $display("FAIL over_round%0d_pulse: got %0d want 1", r, miss_cnt); else passed++;
      checks++; if (lives !== 2'(2 - r)) $display("FAIL over_round%0d_lives: got %0d want %0d", r, lives, 2 - r); else passed++;
      @(negedge clk);
      checks++; if (miss !== 1'b0) $display("FAIL over_round%0d_width: got %b want 0", r, miss); else passed++;
    end
    checks++; if (game_over !== 1'b1) $display("FAIL over_flag: got %b want 1", game_over); else passed++;
    probe(200, 200, c);
    checks++; if (c !== 12'h400) $display("FAIL over_bg: got %h want 400", c); else passed++;
    btn_right = 1'b1;
    ticks(1);
    btn_right = 1'b0;
    probe(0, 464, c);
    checks++; if (c !== 12'h0F0) $display("FAIL over_paddle_frozen: got %h want 0F0", c); else passed++;
    btn_serve = 1'b1;
    ticks(1);
    btn_serve = 1'b0;
    checks++; if (game_over !== 1'b0) $display("FAIL restart_flag: got %b want 0", game_over); else passed++;
    checks++; if (lives !== 2'd3) $display("FAIL restart_lives: got %0d want 3", lives); else passed++;
    probe(200, 200, c);
    checks++; if (c !== 12'h000) $display("FAIL restart_bg: got %h want 000", c); else passed++;
  endtask

  initial begin
    test_reset();
    test_render();
    test_serve();
    test_reflect();
    test_miss();
    test_async_reset();
    test_paddle();
    test_game_over();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
